fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fb_write_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//
// Purpose:
//    Round-robin write arbiter in front of a single-port frame-buffer RAM.
//    Writers get the RAM only while the display reader is idle, which is
//    during horizontal and vertical blanking. The write window closes GUARD
//    cycles early so the last registered write lands before the display
//    reader takes the port back.
//
// Ports:
//    clk          in   pixel clock, all logic on posedge
//    rst          in   synchronous active-high reset
//    hcount       in   [10:0] current horizontal beam position
//    vcount       in   [10:0] current vertical beam position
//    wr_valid     in   [NREQ-1:0] per-requester write request
//    wr_addr      in   [NREQ*AW-1:0] flattened addresses, requester i in slice i
//    wr_data      in   [NREQ*DW-1:0] flattened pixel data, requester i in slice i
//    wr_ready     out  [NREQ-1:0] combinational grant, one-hot or zero
//    mem_we       out  registered RAM write enable
//    mem_addr     out  [AW-1:0] registered RAM address
//    mem_wdata    out  [DW-1:0] registered RAM write data
//    disp_sel     out  registered, 1 hands the RAM port to the display reader
//    vblank_start out  registered one-cycle pulse at the start of vblank
//    stall_cnt    out  [15:0] per-frame contention counter
//
// Configuration:
//    FB_ARB_STALL_CNT_EN  when defined, stall_cnt counts cycles in which a
//                         request is pending but no transfer happens; it
//                         clears at each frame start. When undefined,
//                         stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
   parameter int NREQ     = 2,
   parameter int AW       = 19,
   parameter int DW       = 12,
   parameter int H_ACTIVE = 800,
   parameter int H_TOTAL  = 1056,
   parameter int V_ACTIVE = 600,
   parameter int V_TOTAL  = 628,
   parameter int GUARD    = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [10:0]        hcount,
   input  logic [10:0]        vcount,
   input  logic [NREQ-1:0]    wr_valid,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    wr_ready,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic               disp_sel,
   output logic               vblank_start,
   output logic [15:0]        stall_cnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   // Timing constants sized to the beam counters so comparisons stay 11 bits.
   localparam logic [10:0] HA    = 11'(H_ACTIVE);
   localparam logic [10:0] HT    = 11'(H_TOTAL);
   localparam logic [10:0] HG    = 11'(H_TOTAL - GUARD);
   localparam logic [10:0] VA    = 11'(V_ACTIVE);
   localparam logic [10:0] VT    = 11'(V_TOTAL);
   localparam logic [10:0] VLAST = 11'(V_TOTAL - 1);

   logic [PW-1:0] ptr;
   logic [PW-1:0] next_ptr;
   logic [NREQ-1:0] grant;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic          in_range;
   logic          win;
   logic          xfer;

   // Write window: vertical blanking (except the guard tail of the very last
   // line, just before the first active line of the next frame) plus the
   // horizontal blanking part of every line, minus the guard tail. Beam
   // positions outside the frame are treated as active video so a glitching
   // timing generator can never open the window.
   always_comb begin
      in_range = (hcount < HT) && (vcount < VT);
      win      = in_range &&
                 (((vcount >= VA) && !((vcount == VLAST) && (hcount >= HG))) ||
                  ((hcount >= HA) && (hcount < HG)));
   end

   // Round-robin search: starting at ptr, walk upward with wrap and grant the
   // first valid requester. The winner's payload and the pointer value that
   // follows it are captured here so the registered stage only has to latch.
   always_comb begin
      int idx;
      logic found;
      grant    = '0;
      sel_addr = '0;
      sel_data = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && wr_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            sel_addr    = wr_addr[idx*AW +: AW];
            sel_data    = wr_data[idx*DW +: DW];
            next_ptr    = (idx == NREQ - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   // Grants are only visible inside the window and never during reset, so a
   // request seen while rst is high cannot complete a handshake.
   assign wr_ready = (win && !rst) ? grant : '0;
   assign xfer     = |(wr_valid & wr_ready);

   // Registered RAM port, pointer update and frame-timing outputs. Address
   // and data hold their last value when no write issues so the RAM sees
   // quiet buses between writes. disp_sel follows the window one cycle late,
   // which is exactly what lets the final write in the window complete before
   // the display reader regains the port.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         disp_sel     <= 1'b1;
         vblank_start <= 1'b0;
         ptr          <= '0;
      end else begin
         mem_we       <= xfer;
         disp_sel     <= !win;
         vblank_start <= (hcount == 11'd0) && (vcount == VA);
         if (xfer) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_data;
            ptr       <= next_ptr;
         end
      end
   end

`ifdef FB_ARB_STALL_CNT_EN
   logic [15:0] stall_q;

   // Contention counter: any cycle with a pending request but no transfer is
   // a stall, whether the window is closed or the requester lost arbitration.
   // The frame-start clear wins over a same-cycle stall so each frame starts
   // from exactly zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((hcount == 11'd0) && (vcount == 11'd0)) begin
         stall_q <= '0;
      end else if ((|wr_valid) && !xfer && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_write_arbiter
//
// Directed self-checking bench for fb_write_arbiter with default parameters.
// Each scenario task drives the beam position and requests directly and
// compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fb_write_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 19;
   localparam int DW   = 12;

   localparam logic [AW-1:0] ADDR0 = 19'h12345;
   localparam logic [AW-1:0] ADDR1 = 19'h54321;
   localparam logic [DW-1:0] DATA0 = 12'hABC;
   localparam logic [DW-1:0] DATA1 = 12'h123;

   logic               clk;
   logic               rst;
   logic [10:0]        hcount;
   logic [10:0]        vcount;
   logic [NREQ-1:0]    wr_valid;
   logic [NREQ*AW-1:0] wr_addr;
   logic [NREQ*DW-1:0] wr_data;
   logic [NREQ-1:0]    wr_ready;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic               disp_sel;
   logic               vblank_start;
   logic [15:0]        stall_cnt;

   int n_checks;
   int n_fail;

   fb_write_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .hcount       (hcount),
      .vcount       (vcount),
      .wr_valid     (wr_valid),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .disp_sel     (disp_sel),
      .vblank_start (vblank_start),
      .stall_cnt    (stall_cnt)
   );

   // 10 ns pixel clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge, where registered outputs
   // are stable and new inputs can be applied.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive beam position and requests, then let combinational logic settle.
   task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v,
                                input logic [NREQ-1:0] valid);
      hcount   = h;
      vcount   = v;
      wr_valid = valid;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      applyStimulus(11'd10, 11'd600, 2'b11);
      n_checks++;
      if (wr_ready !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_ready got=%b exp=00", wr_ready);
      end
      tick();
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_memport got we=%b addr=%h data=%h exp 0/0/0",
                  mem_we, mem_addr, mem_wdata);
      end
      n_checks++;
      if (disp_sel !== 1'b1 || vblank_start !== 1'b0 || stall_cnt !== 16'h0) begin
         n_fail++;
         $display("[TB] FAIL reset_misc got disp=%b vbs=%b stall=%0d exp 1/0/0",
                  disp_sel, vblank_start, stall_cnt);
      end
   endtask

   task automatic test_active_video();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         applyStimulus(11'(100 + k), 11'd10, 2'b11);
         n_checks++;
         if (wr_ready !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL active_ready got=%b exp=00", wr_ready);
         end
         tick();
         n_checks++;
         if (mem_we !== 1'b0 || disp_sel !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL active_regs got we=%b disp=%b exp we=0 disp=1",
                     mem_we, disp_sel);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]    exp_ready;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_data;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(11'(10 + k), 11'd600, 2'b11);
         exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr  = (k % 2 == 0) ? ADDR0 : ADDR1;
         exp_data  = (k % 2 == 0) ? DATA0 : DATA1;
         n_checks++;
         if (wr_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL b2b_ready[%0d] got=%b exp=%b", k, wr_ready, exp_ready);
         end
         tick();
         n_checks++;
         if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_wdata !== exp_data) begin
            n_fail++;
            $display("[TB] FAIL b2b_write[%0d] got we=%b addr=%h data=%h exp 1/%h/%h",
                     k, mem_we, mem_addr, mem_wdata, exp_addr, exp_data);
         end
      end
      applyStimulus(11'd14, 11'd600, 2'b00);
      tick();
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== ADDR1 || mem_wdata !== DATA1) begin
         n_fail++;
         $display("[TB] FAIL b2b_hold got we=%b addr=%h data=%h exp 0/%h/%h",
                  mem_we, mem_addr, mem_wdata, ADDR1, DATA1);
      end
   endtask

   task automatic test_guard();
      logic [1:0] exp_ready;
      for (int h = 1050; h <= 1055; h++) begin
         applyStimulus(11'(h), 11'd10, 2'b01);
         exp_ready = (h < 1054) ? 2'b01 : 2'b00;
         n_checks++;
         if (wr_ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL guard_ready h=%0d got=%b exp=%b", h, wr_ready, exp_ready);
         end
         tick();
         n_checks++;
         if (mem_we !== exp_ready[0] || disp_sel !== (h >= 1054)) begin
            n_fail++;
            $display("[TB] FAIL guard_regs h=%0d got we=%b disp=%b exp we=%b disp=%b",
                     h, mem_we, disp_sel, exp_ready[0], (h >= 1054));
         end
      end
   endtask

   task automatic test_window_edges();
      applyStimulus(11'd1053, 11'd627, 2'b10);
      n_checks++;
      if (wr_ready !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL lastline_open got=%b exp=10", wr_ready);
      end
      tick();
      applyStimulus(11'd1054, 11'd627, 2'b10);
      n_checks++;
      if (wr_ready !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL lastline_guard got=%b exp=00", wr_ready);
      end
      tick();
      applyStimulus(11'd1100, 11'd600, 2'b11);
      n_checks++;
      if (wr_ready !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL hrange got=%b exp=00", wr_ready);
      end
      tick();
      applyStimulus(11'd900, 11'd700, 2'b11);
      n_checks++;
      if (wr_ready !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL vrange got=%b exp=00", wr_ready);
      end
      tick();
      n_checks++;
      if (disp_sel !== 1'b1 || mem_we !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL vrange_regs got disp=%b we=%b exp 1/0", disp_sel, mem_we);
      end
   endtask

   task automatic test_vblank_start();
      logic [10:0] hs [3];
      logic [10:0] vs [3];
      logic        ex [3];
      hs = '{11'd0, 11'd0, 11'd1};
      vs = '{11'd599, 11'd600, 11'd600};
      ex = '{1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(hs[k], vs[k], 2'b00);
         tick();
         n_checks++;
         if (vblank_start !== ex[k]) begin
            n_fail++;
            $display("[TB] FAIL vblank_start h=%0d v=%0d got=%b exp=%b",
                     hs[k], vs[k], vblank_start, ex[k]);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      applyStimulus(11'd20, 11'd600, 2'b10);
      n_checks++;
      if (wr_ready !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL burst_ready1 got=%b exp=10", wr_ready);
      end
      tick();
      applyStimulus(11'd21, 11'd600, 2'b01);
      tick();
      rst = 1'b1;
      applyStimulus(11'd22, 11'd600, 2'b10);
      n_checks++;
      if (wr_ready !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL burst_rst_ready got=%b exp=00", wr_ready);
      end
      tick();
      n_checks++;
      if (mem_we !== 1'b0 || mem_addr !== '0) begin
         n_fail++;
         $display("[TB] FAIL burst_rst_regs got we=%b addr=%h exp 0/0", mem_we, mem_addr);
      end
      rst = 1'b0;
      applyStimulus(11'd23, 11'd600, 2'b11);
      n_checks++;
      if (wr_ready !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL burst_first_grant got=%b exp=01", wr_ready);
      end
      tick();
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== ADDR0 || mem_wdata !== DATA0) begin
         n_fail++;
         $display("[TB] FAIL burst_first_write got we=%b addr=%h data=%h exp 1/%h/%h",
                  mem_we, mem_addr, mem_wdata, ADDR0, DATA0);
      end
   endtask

`ifdef FB_ARB_STALL_CNT_EN
   task automatic test_stall_cnt();
      rst = 1'b1;
      applyStimulus(11'd0, 11'd10, 2'b00);
      tick();
      rst = 1'b0;
      for (int h = 0; h < 800; h++) begin
         applyStimulus(11'(h), 11'd10, 2'b01);
         tick();
      end
      n_checks++;
      if (stall_cnt !== 16'd800) begin
         n_fail++;
         $display("[TB] FAIL stall_line got=%0d exp=800", stall_cnt);
      end
      applyStimulus(11'd0, 11'd0, 2'b01);
      tick();
      n_checks++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL stall_clear got=%0d exp=0", stall_cnt);
      end
      applyStimulus(11'd1, 11'd0, 2'b01);
      tick();
      n_checks++;
      if (stall_cnt !== 16'd1) begin
         n_fail++;
         $display("[TB] FAIL stall_restart got=%0d exp=1", stall_cnt);
      end
   endtask
`else
   task automatic test_stall_cnt();
      applyStimulus(11'd100, 11'd10, 2'b11);
      tick();
      tick();
      n_checks++;
      if (stall_cnt !== 16'd0) begin
         n_fail++;
         $display("[TB] FAIL stall_disabled got=%0d exp=0", stall_cnt);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      hcount   = '0;
      vcount   = '0;
      wr_valid = '0;
      wr_addr  = {ADDR1, ADDR0};
      wr_data  = {DATA1, DATA0};

      test_reset();
      test_active_video();
      test_back_to_back();
      test_guard();
      test_window_edges();
      test_vblank_start();
      test_reset_mid_burst();
      test_stall_cnt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
